// File: rtl/tft_pkg.sv
// Shared definitions for the TFT command sequencer.
//   - ROM entry type codes (COMM / DATA / WAIT / END) and the 10-bit entry width
//   - TFT opcodes used by the runtime window set-up
//   - controller state encoding
//   - win_byte(): byte/dc pair for position idx of the 11-byte window burst
package tft_pkg;

  localparam int ENTRY_W   = 10;
  localparam int WIN_BYTES = 11;

  localparam logic [7:0] CASET = 8'h2A;
  localparam logic [7:0] PASET = 8'h2B;
  localparam logic [7:0] RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    ENT_COMM = 2'b00,
    ENT_DATA = 2'b01,
    ENT_WAIT = 2'b10,
    ENT_END  = 2'b11
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_FETCH,
    ST_SEND,
    ST_DELAY,
    ST_READY,
    ST_WIN
  } state_t;

  // Returns {dc, byte}. Coordinates arrive zero-extended to 16 bits.
  function automatic logic [8:0] win_byte(input logic [3:0]  idx,
                                          input logic [15:0] x0,
                                          input logic [15:0] x1,
                                          input logic [15:0] y0,
                                          input logic [15:0] y1);
    logic [8:0] b;
    case (idx)
      4'd0:    b = {1'b0, CASET};
      4'd1:    b = {1'b1, x0[15:8]};
      4'd2:    b = {1'b1, x0[7:0]};
      4'd3:    b = {1'b1, x1[15:8]};
      4'd4:    b = {1'b1, x1[7:0]};
      4'd5:    b = {1'b0, PASET};
      4'd6:    b = {1'b1, y0[15:8]};
      4'd7:    b = {1'b1, y0[7:0]};
      4'd8:    b = {1'b1, y1[15:8]};
      4'd9:    b = {1'b1, y1[7:0]};
      4'd10:   b = {1'b0, RAMWR};
      default: b = 9'h000;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// Millisecond delay timer.
//   load  : restart the prescaler and load the ms count
//   ms    : delay in milliseconds (sampled on load)
//   run   : prescaler advances only while high
//   done  : count has reached zero
// The first ms elapses exactly CLK_HZ/1000 cycles after the first run cycle
// following a load.
module ms_timer #(
  parameter int CLK_HZ = 50000000,
  parameter int WAIT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] ms,
  input  logic              run,
  output logic              done
);

  localparam int TICK  = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int PRE_W = (TICK > 1) ? $clog2(TICK) : 1;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              tick;

  assign tick = run && (pre_q == PRE_W'(TICK - 1));
  assign done = (cnt_q == '0);

  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (load) begin
      pre_d = '0;
      cnt_d = ms;
    end else if (run) begin
      if (tick) begin
        pre_d = '0;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tft_cmd_sequencer.sv
// TFT command sequencer.
// Replays a ROM of {type[1:0], payload[7:0]} entries to the byte transmitter,
// then sits in READY serving window requests with a CASET/PASET/RAMWR burst.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    begin / replay the init sequence (ignored while busy)
//   tft_busy                 transmitter busy
//   win_req, win_x0..win_y1  window request (level) and inclusive bounds
//   tft_dc/tft_data          byte and command(0)/data(1) flag, held between strobes
//   tft_transmit             one-cycle send strobe
//   busy, init_done          status
//   win_ack, win_err         one-cycle request accept / reject pulses
// ROM contents come from ROM_INIT (entry i at bits [i*10 +: 10]).
module tft_cmd_sequencer
  import tft_pkg::*;
#(
  parameter int                           CLK_HZ   = 50000000,
  parameter int                           SEQ_LEN  = 64,
  parameter string                        ROM_FILE = "tft_init.mem",
  parameter logic [SEQ_LEN*ENTRY_W-1:0]   ROM_INIT = '0,
  parameter int                           COORD_W  = 16,
  parameter int                           WAIT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tft_busy,
  input  logic               win_req,
  input  logic [COORD_W-1:0] win_x0,
  input  logic [COORD_W-1:0] win_x1,
  input  logic [COORD_W-1:0] win_y0,
  input  logic [COORD_W-1:0] win_y1,
  output logic               tft_dc,
  output logic [7:0]         tft_data,
  output logic               tft_transmit,
  output logic               busy,
  output logic               init_done,
  output logic               win_ack,
  output logic               win_err
);

  localparam int IDX_W  = $clog2(SEQ_LEN + 1);
  localparam int ADDR_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  // ROM with one-cycle registered read. The address is taken from the
  // next-state index so the entry is already valid in INIT_FETCH.
  logic [ENTRY_W-1:0] rom [SEQ_LEN];
  logic [ENTRY_W-1:0] rom_q;
  logic [ADDR_W-1:0]  rom_addr;

  for (genvar i = 0; i < SEQ_LEN; i++) begin : g_ent
    assign rom[i] = ROM_INIT[i*ENTRY_W +: ENTRY_W];
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [3:0]         win_idx_q, win_idx_d;
  logic               in_win_q, in_win_d;
  logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic               tft_transmit_q, tft_transmit_d;
  logic               tft_dc_q, tft_dc_d;
  logic [7:0]         tft_data_q, tft_data_d;
  logic               guard_q, guard_d;
  logic               win_ack_q, win_ack_d;
  logic               win_err_q, win_err_d;
  logic               err_block_q, err_block_d;

  logic               tmr_load, tmr_done;
  logic               send_ok;
  logic [8:0]         win_pair;
  entry_t             ent_type;

  assign rom_addr = (index_d >= IDX_W'(SEQ_LEN)) ? '0 : index_d[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    rom_q <= rom[rom_addr];
  end

  ms_timer #(
    .CLK_HZ (CLK_HZ),
    .WAIT_W (WAIT_W)
  ) u_ms_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .ms   (WAIT_W'(rom_q[7:0])),
    .run  (state_q == ST_DELAY),
    .done (tmr_done)
  );

  assign ent_type = entry_t'(rom_q[9:8]);

  // Never strobe in the strobe cycle or the one after it: a transmitter that
  // raises busy a cycle late must still be seen before the next strobe.
  assign send_ok  = !tft_busy && !tft_transmit_q && !guard_q;

  assign win_pair = win_byte(win_idx_q, 16'(x0_q), 16'(x1_q), 16'(y0_q), 16'(y1_q));

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    win_idx_d      = win_idx_q;
    in_win_d       = in_win_q;
    x0_d           = x0_q;
    x1_d           = x1_q;
    y0_d           = y0_q;
    y1_d           = y1_q;
    tft_transmit_d = 1'b0;
    tft_dc_d       = tft_dc_q;
    tft_data_d     = tft_data_q;
    guard_d        = tft_transmit_q;
    win_ack_d      = 1'b0;
    win_err_d      = 1'b0;
    err_block_d    = err_block_q && win_req;
    tmr_load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          index_d  = '0;
          in_win_d = 1'b0;
          state_d  = ST_INIT_FETCH;
        end
      end

      ST_INIT_FETCH: begin
        if (index_q == IDX_W'(SEQ_LEN)) begin
          state_d = ST_READY;
        end else begin
          case (ent_type)
            ENT_COMM, ENT_DATA: state_d = ST_SEND;
            ENT_WAIT: begin
              tmr_load = 1'b1;
              state_d  = ST_DELAY;
            end
            default: state_d = ST_READY;
          endcase
        end
      end

      ST_SEND: begin
        if (send_ok) begin
          tft_transmit_d = 1'b1;
          if (in_win_q) begin
            {tft_dc_d, tft_data_d} = win_pair;
            if (win_idx_q == 4'(WIN_BYTES - 1)) begin
              in_win_d = 1'b0;
              state_d  = ST_READY;
            end else begin
              win_idx_d = win_idx_q + 4'd1;
              state_d   = ST_WIN;
            end
          end else begin
            tft_dc_d   = (ent_type == ENT_DATA);
            tft_data_d = rom_q[7:0];
            index_d    = index_q + 1'b1;
            state_d    = ST_INIT_FETCH;
          end
        end
      end

      ST_DELAY: begin
        if (tmr_done) begin
          index_d = index_q + 1'b1;
          state_d = ST_INIT_FETCH;
        end
      end

      ST_READY: begin
        if (start) begin
          index_d  = '0;
          in_win_d = 1'b0;
          state_d  = ST_INIT_FETCH;
        end else if (win_req && !err_block_q) begin
          if (win_x0 <= win_x1 && win_y0 <= win_y1) begin
            x0_d      = win_x0;
            x1_d      = win_x1;
            y0_d      = win_y0;
            y1_d      = win_y1;
            win_ack_d = 1'b1;
            win_idx_d = '0;
            in_win_d  = 1'b1;
            state_d   = ST_WIN;
          end else begin
            // Rejected requests stay blocked until win_req drops.
            win_err_d   = 1'b1;
            err_block_d = 1'b1;
          end
        end
      end

      ST_WIN: state_d = ST_SEND;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      index_q        <= '0;
      win_idx_q      <= '0;
      in_win_q       <= 1'b0;
      x0_q           <= '0;
      x1_q           <= '0;
      y0_q           <= '0;
      y1_q           <= '0;
      tft_transmit_q <= 1'b0;
      tft_dc_q       <= 1'b0;
      tft_data_q     <= '0;
      guard_q        <= 1'b0;
      win_ack_q      <= 1'b0;
      win_err_q      <= 1'b0;
      err_block_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      win_idx_q      <= win_idx_d;
      in_win_q       <= in_win_d;
      x0_q           <= x0_d;
      x1_q           <= x1_d;
      y0_q           <= y0_d;
      y1_q           <= y1_d;
      tft_transmit_q <= tft_transmit_d;
      tft_dc_q       <= tft_dc_d;
      tft_data_q     <= tft_data_d;
      guard_q        <= guard_d;
      win_ack_q      <= win_ack_d;
      win_err_q      <= win_err_d;
      err_block_q    <= err_block_d;
    end
  end

  assign tft_transmit = tft_transmit_q;
  assign tft_dc       = tft_dc_q;
  assign tft_data     = tft_data_q;
  assign win_ack      = win_ack_q;
  assign win_err      = win_err_q;
  assign init_done    = (state_q == ST_READY);
  assign busy         = (state_q != ST_IDLE) && (state_q != ST_READY);

endmodule

// File: tb/tb_tft_cmd_sequencer.sv
// Bench for tft_cmd_sequencer: randomized window traffic against a
// sequence/window reference model, scoreboard checked by a strobe monitor.
module tb_tft_cmd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, start = 1'b0, tft_busy = 1'b0, win_req = 1'b0;
  logic [15:0] win_x0 = '0, win_x1 = '0, win_y0 = '0, win_y1 = '0;
  logic        tft_dc, tft_transmit, busy, init_done, win_ack, win_err;
  logic [7:0]  tft_data;

  // Second instance: 4-entry ROM without END, zero-length wait inside.
  logic        b_start = 1'b0, b_busy_in = 1'b0, b_req = 1'b0;
  logic [15:0] b_zero = '0;
  logic        b_dc, b_transmit, b_busy, b_done, b_ack, b_err;
  logic [7:0]  b_data;

  localparam logic [79:0] ROM_A = {10'h000, 10'h000, 10'h300, 10'h029,
                                   10'h200, 10'h202, 10'h117, 10'h0C0};
  localparam logic [39:0] ROM_B = {10'h033, 10'h122, 10'h200, 10'h011};

  logic [9:0] rom_a_tab [8] = '{10'h0C0, 10'h117, 10'h202, 10'h200,
                                10'h029, 10'h300, 10'h000, 10'h000};
  // Entries past index 3 must never be played by the 4-deep instance.
  logic [9:0] rom_b_tab [8] = '{10'h011, 10'h200, 10'h122, 10'h033,
                                10'h0EE, 10'h0EE, 10'h0EE, 10'h0EE};

  tft_cmd_sequencer #(
    .CLK_HZ(4000), .SEQ_LEN(8), .ROM_FILE(""), .ROM_INIT(ROM_A),
    .COORD_W(16), .WAIT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .tft_busy(tft_busy),
    .win_req(win_req), .win_x0(win_x0), .win_x1(win_x1),
    .win_y0(win_y0), .win_y1(win_y1),
    .tft_dc(tft_dc), .tft_data(tft_data), .tft_transmit(tft_transmit),
    .busy(busy), .init_done(init_done), .win_ack(win_ack), .win_err(win_err)
  );

  tft_cmd_sequencer #(
    .CLK_HZ(4000), .SEQ_LEN(4), .ROM_FILE(""), .ROM_INIT(ROM_B),
    .COORD_W(16), .WAIT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .tft_busy(b_busy_in),
    .win_req(b_req), .win_x0(b_zero), .win_x1(b_zero),
    .win_y0(b_zero), .win_y1(b_zero),
    .tft_dc(b_dc), .tft_data(b_data), .tft_transmit(b_transmit),
    .busy(b_busy), .init_done(b_done), .win_ack(b_ack), .win_err(b_err)
  );

  int total = 0, bad = 0;
  int cyc = 0, ack_cnt = 0, err_cnt = 0, exp_ack = 0, exp_err = 0;
  logic [8:0] exp_q [$];
  logic [8:0] b_exp [$];
  logic [8:0] b_got [$];
  int         stimes [$];
  logic [7:0] sched = '0;
  bit         late = 1'b0, prev_strobe = 1'b0;

  task automatic chk(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: play ROM entries in order until END or n entries.
  task automatic push_seq(input logic [9:0] tab [8], input int n, input bit to_b);
    for (int i = 0; i < n; i++) begin
      logic [9:0] e;
      e = tab[i];
      if (e[9:8] == 2'b11) break;
      if (e[9:8] == 2'b00 || e[9:8] == 2'b01) begin
        if (to_b) b_exp.push_back({e[8], e[7:0]});
        else      exp_q.push_back({e[8], e[7:0]});
      end
    end
  endtask

  task automatic push_win(input int x0, input int x1, input int y0, input int y1);
    exp_q.push_back({1'b0, 8'h2A});
    exp_q.push_back({1'b1, 8'(x0 / 256)}); exp_q.push_back({1'b1, 8'(x0 % 256)});
    exp_q.push_back({1'b1, 8'(x1 / 256)}); exp_q.push_back({1'b1, 8'(x1 % 256)});
    exp_q.push_back({1'b0, 8'h2B});
    exp_q.push_back({1'b1, 8'(y0 / 256)}); exp_q.push_back({1'b1, 8'(y0 % 256)});
    exp_q.push_back({1'b1, 8'(y1 / 256)}); exp_q.push_back({1'b1, 8'(y1 % 256)});
    exp_q.push_back({1'b0, 8'h2C});
  endtask

  task automatic wait_done(input int max, input string nm);
    int n;
    n = 0;
    while (!init_done && n < max) begin
      tick();
      n++;
    end
    total++;
    if (!init_done) begin
      bad++;
      $display("FAIL %s: init_done not seen within %0d cycles (got 0 expected 1)", nm, max);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_win(input logic [15:0] x0, input logic [15:0] x1,
                        input logic [15:0] y0, input logic [15:0] y1);
    bit ok;
    int n0;
    ok = (x0 <= x1) && (y0 <= y1);
    n0 = stimes.size();
    win_x0 = x0; win_x1 = x1; win_y0 = y0; win_y1 = y1;
    if (ok) begin
      push_win(int'(x0), int'(x1), int'(y0), int'(y1));
      exp_ack++;
    end else begin
      exp_err++;
    end
    win_req = 1'b1;
    tick();
    if (!ok) repeat (2) tick();
    win_req = 1'b0;
    // Inputs change after the request; latched values must be used.
    win_x0 = 16'($urandom); win_x1 = 16'($urandom);
    win_y0 = 16'($urandom); win_y1 = 16'($urandom);
    if (ok) wait_done(600, "win_done");
    repeat (3) tick();
    chk("ack_count", ack_cnt, exp_ack);
    chk("err_count", err_cnt, exp_err);
    chk("win_queue_drained", exp_q.size(), 0);
    chk("ready_after_win", init_done, 1);
    if (!ok) chk("no_strobe_on_err", stimes.size(), n0);
  endtask

  // Strobe monitor, scoreboard and transmitter busy model in one process so
  // the busy value checked is the one the DUT sampled for its decision.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sched       = '0;
      tft_busy    = 1'b0;
      prev_strobe = 1'b0;
    end else begin
      if (tft_transmit) begin
        stimes.push_back(cyc);
        total++;
        if (prev_strobe) begin
          bad++;
          $display("FAIL back_to_back_strobe: cycle %0d got 1 expected 0", cyc);
        end
        total++;
        if (tft_busy) begin
          bad++;
          $display("FAIL strobe_while_busy: cycle %0d got busy=1 expected 0", cyc);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: got %0h expected none", {tft_dc, tft_data});
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          if ({tft_dc, tft_data} != e) begin
            bad++;
            $display("FAIL strobe_byte: got dc=%0d data=%02h expected dc=%0d data=%02h",
                     tft_dc, tft_data, e[8], e[7:0]);
          end
        end
      end
      if (win_ack) ack_cnt++;
      if (win_err) err_cnt++;
      prev_strobe = tft_transmit;
      sched    = sched >> 1;
      tft_busy = sched[0];
      if (tft_transmit) sched = sched | (8'b0000_0111 << (late ? 2 : 1));
    end
  end

  always @(negedge clk) begin
    if (!rst && b_transmit) b_got.push_back({b_dc, b_data});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_transmit", tft_transmit, 0);
    chk("rst_dc", tft_dc, 0);
    chk("rst_data", tft_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ack_err", {win_ack, win_err}, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Normal init
    stimes.delete();
    push_seq(rom_a_tab, 8, 1'b0);
    pulse_start();
    chk("busy_during_init", busy, 1);
    wait_done(400, "init_done");
    repeat (3) tick();
    chk("init_strobes", stimes.size(), 3);
    chk("init_queue_drained", exp_q.size(), 0);
    if (stimes.size() == 3) chk("delay_gap_ge_8", (stimes[2] - stimes[1]) >= 8, 1);
    chk("init_done_high", init_done, 1);

    // Full-screen window, then an inverted one
    do_win(16'd0, 16'd319, 16'd0, 16'd479);
    do_win(16'd10, 16'd5, 16'd0, 16'd0);

    // Randomized windows, alternating normal and late-busy transmitter
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a, b, c, d, t;
      late = i[0];
      a = 16'($urandom); b = 16'($urandom);
      c = 16'($urandom); d = 16'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (a > b) begin t = a; a = b; b = t; end
        if (c > d) begin t = c; c = d; d = t; end
      end
      do_win(a, b, c, d);
    end
    late = 1'b0;

    // Reset in the middle of the WAIT entry
    stimes.delete();
    push_seq(rom_a_tab, 8, 1'b0);
    pulse_start();
    for (int n = 0; n < 200 && stimes.size() < 2; n++) tick();
    chk("pre_reset_strobes", stimes.size(), 2);
    repeat (3) tick();
    chk("busy_in_delay", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    chk("midrst_transmit", tft_transmit, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    repeat (12) tick();
    chk("after_rst_idle", busy, 0);
    stimes.delete();
    push_seq(rom_a_tab, 8, 1'b0);
    pulse_start();
    wait_done(400, "replay_done");
    repeat (3) tick();
    chk("replay_strobes", stimes.size(), 3);
    chk("replay_queue_drained", exp_q.size(), 0);

    // start and win_req together in READY: start wins
    stimes.delete();
    push_seq(rom_a_tab, 8, 1'b0);
    win_x0 = 16'd1; win_x1 = 16'd2; win_y0 = 16'd3; win_y1 = 16'd4;
    win_req = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    win_req = 1'b0;
    wait_done(400, "start_wins_done");
    repeat (3) tick();
    chk("start_wins_no_ack", ack_cnt, exp_ack);
    chk("start_wins_strobes", stimes.size(), 3);
    chk("start_wins_queue", exp_q.size(), 0);

    // SEQ_LEN boundary with no END entry
    push_seq(rom_b_tab, 4, 1'b1);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int n = 0; n < 200 && !b_done; n++) tick();
    chk("seqlen_done", b_done, 1);
    repeat (3) tick();
    chk("seqlen_count", b_got.size(), b_exp.size());
    for (int i = 0; i < b_exp.size() && i < b_got.size(); i++)
      chk($sformatf("seqlen_byte%0d", i), b_got[i], b_exp[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
